vector_mask_writeback: RTL and testbench
========================================

// Module: vector_mask_writeback
// PURPOSE
//  Consumer end of the vector ALU interface: takes per-lane results and LT comparison
//  flags (LANES x DATA_WIDTH data, LANES flag bits), holds the architectural lane mask,
//  applies that mask to result data, and buffers masked writes to the vector register file.
//  Sits between the EX-stage vector ALU and the vector register file write port.
// PARAMETERS
//  DATA_WIDTH     8  bits per lane
//  LANES          6  lanes per vector
//  SELECTOR_SIZE  3  ALU selector width
//  REG_ADDR_W     4  vector register address width
//  FIFO_DEPTH     2  writeback buffer entries (fixed at 2; count states below)
// PORTS
//  clk            in   1                  clock, rising edge
//  rst_n          in   1                  asynchronous, active-low reset
//  in_valid       in   1                  ALU result valid
//  in_ready       out  1                  block can accept (buffer not full)
//  in_selector    in   SELECTOR_SIZE      ALU operation code of this result
//  in_result      in   LANES*DATA_WIDTH   ALU data output
//  in_comparison  in   LANES              ALU comparison flags (bit i = lane i)
//  in_old         in   LANES*DATA_WIDTH   current destination register contents
//  in_dest        in   REG_ADDR_W         destination vector register
//  in_masked      in   1                  1 = apply lane mask, 0 = write all lanes
//  mask_clear     in   1                  sideband: set mask to all ones
//  wb_valid       out  1                  write entry available
//  wb_ready       in   1                  register file takes entry
//  wb_addr        out  REG_ADDR_W         write address
//  wb_data        out  LANES*DATA_WIDTH   merged write data
//  mask_out       out  LANES              current lane mask
// BEHAVIOUR
//  - Reset (async assert, sync release): mask_out = all ones; buffer empty; wb_valid = 0,
//    wb_addr = 0, wb_data = 0; in_ready = 1. Reset mid-operation discards buffered entries.
//  - Accept = in_valid && in_ready; pop = wb_valid && wb_ready.
//  - in_ready = (count != 2); no bypass: a full buffer refuses input even during a pop.
//  - Selector 3'b011 (LT): on accept, mask <= in_comparison at next edge; nothing is enqueued.
//  - All other selectors: on accept, enqueue {in_dest, merged}; merged lane i =
//    (!in_masked || mask[i]) ? in_result[i] : in_old[i], using mask value before this edge.
//  - mask_clear: mask <= all ones at next edge; if an LT accept occurs same cycle, the LT
//    update wins. An op accepted in the same cycle as mask_clear uses the pre-clear mask.
//  - Buffer FSM on count: EMPTY(0) -> ONE on accept-only; ONE -> TWO on accept-only,
//    ONE -> EMPTY on pop-only, ONE stays on accept+pop; TWO -> ONE on pop.
//    EMPTY never pops (wb_valid = 0); accept+pop in EMPTY impossible.
//  - LT accepts never change count; an LT accept and a pop in the same cycle both happen.
//  - Latency: accept at edge N -> wb_valid/wb_addr/wb_data of that entry visible after
//    edge N when buffer was empty. Strict FIFO order; wb_* stable while wb_valid && !wb_ready.
//  - Read/write pointers 1 bit, wrap modulo 2. wb_data/wb_addr hold last value when empty.
//  - No arithmetic; widths are pure pass-through per lane.
// STRUCTURE
//  - Package vector_pkg: DATA_WIDTH, LANES, SELECTOR_SIZE, REG_ADDR_W constants;
//    enum sel_e {SEL_ADD=3'b000, SEL_SUB=3'b001, SEL_FPMUL=3'b010, SEL_LT=3'b011,
//    SEL_MOV1=3'b110, SEL_MOV2=3'b111}; typedef lane vector type; struct wb_entry_t {addr, data};
//    enum buf_state_e {EMPTY, ONE, TWO}.
//  - Sub-module vector_wb_fifo: 2-entry valid/ready FIFO of wb_entry_t; mask register and
//    lane merge stay in this module.
// TESTING
//  - Reset: rst_n=0 mid-stream with 2 entries queued -> immediately wb_valid=0, mask_out=6'b111111, in_ready=1.
//  - LT then masked ADD: accept sel=011 cmp=6'b000101; then sel=000 masked, result lanes all 8'hAA,
//    old all 8'h11, dest=3 -> wb_addr=3, lanes0,2=8'hAA, lanes1,3,4,5=8'h11.
//  - Unmasked write: mask=6'b000000, in_masked=0, result all 8'h5C -> all lanes 8'h5C.
//  - Backpressure: wb_ready=0, three non-LT accepts attempted -> in_ready=0 after second; first
//    entry stable on wb_*; release wb_ready -> entries out in order, third accepted after pop.
//  - Simultaneous: mask_clear=1 with LT accept cmp=6'b100000 -> mask_out=6'b100000; mask_clear
//    alone next cycle -> 6'b111111.
//  - Accept+pop in ONE state, 20 back-to-back ops with wb_ready=1 -> one write per cycle, count stays ONE.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared constants and types for the vector ALU writeback path.
package vector_pkg;

    localparam int unsigned DATA_WIDTH    = 8;
    localparam int unsigned LANES         = 6;
    localparam int unsigned SELECTOR_SIZE = 3;
    localparam int unsigned REG_ADDR_W    = 4;
    localparam int unsigned VEC_W         = LANES * DATA_WIDTH;

    typedef enum logic [SELECTOR_SIZE-1:0] {
        SEL_ADD   = 3'b000,
        SEL_SUB   = 3'b001,
        SEL_FPMUL = 3'b010,
        SEL_LT    = 3'b011,
        SEL_MOV1  = 3'b110,
        SEL_MOV2  = 3'b111
    } sel_e;

    typedef logic [LANES-1:0][DATA_WIDTH-1:0] lane_vec_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        lane_vec_t             data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/vector_wb_fifo.sv
// Two-entry valid/ready FIFO of register-file write entries; all outputs registered.
module vector_wb_fifo
    import vector_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_valid,
    output logic      push_ready,
    input  wb_entry_t push_entry,
    output logic      pop_valid,
    input  logic      pop_ready,
    output wb_entry_t pop_entry
);

    buf_state_e state_q, state_d;
    wb_entry_t  mem_q [2];
    logic       wptr_q, rptr_q, wptr_d, rptr_d;
    logic       push, pop;
    wb_entry_t  head_d;

    assign push = push_valid && push_ready;
    assign pop  = pop_valid && pop_ready;

    // Next occupancy, pointers, and the entry that will sit at the head after this edge.
    always_comb begin
        state_d = state_q;
        wptr_d  = push ? ~wptr_q : wptr_q;
        rptr_d  = pop  ? ~rptr_q : rptr_q;
        head_d  = mem_q[rptr_d];
        if (push && (wptr_q == rptr_d)) begin
            head_d = push_entry;
        end
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = TWO;
                else if (!push && pop) state_d = EMPTY;
            end
            TWO:   if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            push_ready <= 1'b1;
            pop_valid  <= 1'b0;
            pop_entry  <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            push_ready <= (state_d != TWO);
            pop_valid  <= (state_d != EMPTY);
            // Head holds its last value once the buffer drains.
            if (state_d != EMPTY) begin
                pop_entry <= head_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push) begin
            mem_q[wptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/vector_mask_writeback.sv
// Vector ALU consumer: holds the lane mask, merges masked results, and buffers register-file writes.
module vector_mask_writeback
    import vector_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SELECTOR_SIZE-1:0]   in_selector,
    input  logic [LANES*DATA_WIDTH-1:0] in_result,
    input  logic [LANES-1:0]           in_comparison,
    input  logic [LANES*DATA_WIDTH-1:0] in_old,
    input  logic [REG_ADDR_W-1:0]      in_dest,
    input  logic                       in_masked,
    input  logic                       mask_clear,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [REG_ADDR_W-1:0]      wb_addr,
    output logic [LANES*DATA_WIDTH-1:0] wb_data,
    output logic [LANES-1:0]           mask_out
);

    logic [LANES-1:0] mask_q;
    logic             is_lt;
    logic             lt_accept;
    logic             push_valid;
    lane_vec_t        result_v, old_v, merged;
    wb_entry_t        push_entry, pop_entry;

    assign is_lt      = (in_selector == SEL_LT);
    assign lt_accept  = in_valid && in_ready && is_lt;
    assign push_valid = in_valid && !is_lt;
    assign result_v   = lane_vec_t'(in_result);
    assign old_v      = lane_vec_t'(in_old);

    // Lane merge uses the mask as it stands before this edge.
    always_comb begin
        merged = old_v;
        for (int i = 0; i < int'(LANES); i++) begin
            if (!in_masked || mask_q[i]) begin
                merged[i] = result_v[i];
            end
        end
    end

    assign push_entry = '{addr: in_dest, data: merged};

    // An LT accept overrides a concurrent mask_clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '1;
        end else if (lt_accept) begin
            mask_q <= in_comparison;
        end else if (mask_clear) begin
            mask_q <= '1;
        end
    end

    vector_wb_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_ready (in_ready),
        .push_entry (push_entry),
        .pop_valid  (wb_valid),
        .pop_ready  (wb_ready),
        .pop_entry  (pop_entry)
    );

    assign wb_addr  = pop_entry.addr;
    assign wb_data  = VEC_W'(pop_entry.data);
    assign mask_out = mask_q;

endmodule

// File: tb/tb_vector_mask_writeback.sv
// Directed bench for vector_mask_writeback with a queue-based writeback scoreboard.
module tb_vector_mask_writeback;
    import vector_pkg::*;

    localparam int unsigned DW = LANES * DATA_WIDTH;

    typedef struct {
        logic [REG_ADDR_W-1:0] addr;
        logic [DW-1:0]         data;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [SELECTOR_SIZE-1:0] in_selector;
    logic [DW-1:0]            in_result;
    logic [LANES-1:0]         in_comparison;
    logic [DW-1:0]            in_old;
    logic [REG_ADDR_W-1:0]    in_dest;
    logic                     in_masked;
    logic                     mask_clear;
    logic                     wb_valid;
    logic                     wb_ready;
    logic [REG_ADDR_W-1:0]    wb_addr;
    logic [DW-1:0]            wb_data;
    logic [LANES-1:0]         mask_out;

    exp_t             sb[$];
    logic [LANES-1:0] model_mask;
    int               n_cmp = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    vector_mask_writeback dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_selector   (in_selector),
        .in_result     (in_result),
        .in_comparison (in_comparison),
        .in_old        (in_old),
        .in_dest       (in_dest),
        .in_masked     (in_masked),
        .mask_clear    (mask_clear),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .mask_out      (mask_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] res, input logic [DW-1:0] old,
                                            input logic msk, input logic [LANES-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < int'(LANES); i++)
            if (!msk || m[i]) r[i*DATA_WIDTH +: DATA_WIDTH] = res[i*DATA_WIDTH +: DATA_WIDTH];
        return r;
    endfunction

    // One clock: check outputs at the falling edge, advance the model, then move past the rising edge.
    task automatic step();
        exp_t e;
        int   cnt;
        @(negedge clk);
        cnt = sb.size();
        chk("in_ready", 64'(in_ready), 64'(cnt != 2));
        chk("wb_valid", 64'(wb_valid), 64'(cnt != 0));
        chk("mask_out", 64'(mask_out), 64'(model_mask));
        if (cnt != 0) begin
            chk("wb_addr", 64'(wb_addr), 64'(sb[0].addr));
            chk("wb_data", 64'(wb_data), 64'(sb[0].data));
            if (wb_ready) void'(sb.pop_front());
        end
        if (in_valid && cnt != 2) begin
            if (in_selector == 3'b011) begin
                model_mask = in_comparison;
            end else begin
                e.addr = in_dest;
                e.data = merge(in_result, in_old, in_masked, model_mask);
                sb.push_back(e);
                if (mask_clear) model_mask = '1;
            end
        end else if (mask_clear) begin
            model_mask = '1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic [DW-1:0] res,
                         input logic [DW-1:0] old, input logic [3:0] dst, input logic msk,
                         input logic [5:0] cmp);
        in_valid = v; in_selector = sel; in_result = res; in_old = old;
        in_dest = dst; in_masked = msk; in_comparison = cmp;
    endtask

    initial begin
        rst_n = 1'b0; mask_clear = 1'b0; wb_ready = 1'b1;
        drive(1'b0, 3'b000, '0, '0, 4'd0, 1'b0, 6'd0);
        model_mask = '1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mask", 64'(mask_out), 64'h3f);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_wb_addr", 64'(wb_addr), 64'd0);
        step();

        // LT then masked ADD
        drive(1'b1, 3'b011, '0, '0, 4'd0, 1'b0, 6'b000101); step();
        drive(1'b1, 3'b000, {6{8'hAA}}, {6{8'h11}}, 4'd3, 1'b1, 6'd0); step();
        drive(1'b0, 3'b000, '0, '0, 4'd0, 1'b0, 6'd0);
        chk("lt_mask", 64'(mask_out), 64'h05);
        chk("masked_addr", 64'(wb_addr), 64'd3);
        chk("masked_data", 64'(wb_data), 64'h111111AA11AA);
        step();

        // unmasked write under an all-zero mask
        drive(1'b1, 3'b011, '0, '0, 4'd0, 1'b0, 6'b000000); step();
        drive(1'b1, 3'b110, {6{8'h5C}}, '0, 4'd7, 1'b0, 6'd0); step();
        drive(1'b0, 3'b000, '0, '0, 4'd0, 1'b0, 6'd0);
        chk("unmasked_data", 64'(wb_data), 64'h5C5C5C5C5C5C);
        step();
        drive(1'b1, 3'b001, {6{8'h77}}, {6{8'h22}}, 4'd9, 1'b1, 6'd0); step();
        drive(1'b0, 3'b000, '0, '0, 4'd0, 1'b0, 6'd0);
        chk("zero_mask_data", 64'(wb_data), 64'h222222222222);
        step();

        // backpressure: fill, refuse third, then drain in order
        mask_clear = 1'b1; step(); mask_clear = 1'b0;
        wb_ready = 1'b0;
        drive(1'b1, 3'b000, 48'h010203040506, '0, 4'd1, 1'b0, 6'd0); step();
        drive(1'b1, 3'b001, 48'h111213141516, '0, 4'd2, 1'b0, 6'd0); step();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 3'b010, 48'h212223242526, '0, 4'd4, 1'b0, 6'd0);
        step(); step();
        chk("bp_hold_data", 64'(wb_data), 64'h010203040506);
        chk("bp_hold_addr", 64'(wb_addr), 64'd1);
        wb_ready = 1'b1;
        step(); step();
        drive(1'b0, 3'b000, '0, '0, 4'd0, 1'b0, 6'd0);
        repeat (3) step();

        // mask_clear with a concurrent LT accept, then alone
        mask_clear = 1'b1;
        drive(1'b1, 3'b011, '0, '0, 4'd0, 1'b0, 6'b100000); step();
        drive(1'b0, 3'b000, '0, '0, 4'd0, 1'b0, 6'd0);
        chk("clr_lt_mask", 64'(mask_out), 64'h20);
        step();
        mask_clear = 1'b0;
        chk("clr_mask", 64'(mask_out), 64'h3f);
        drive(1'b1, 3'b011, '0, '0, 4'd0, 1'b0, 6'b011010); step();

        // 20 back-to-back ops with continuous drain
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 3'b111, {$urandom(), 16'($urandom())}, {$urandom(), 16'($urandom())},
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 6'd0);
            step();
            if (k > 0) chk("b2b_one", 64'(sb.size()), 64'd1);
        end
        drive(1'b0, 3'b000, '0, '0, 4'd0, 1'b0, 6'd0);
        repeat (2) step();

        // reset mid-stream with two entries queued
        wb_ready = 1'b0;
        drive(1'b1, 3'b011, '0, '0, 4'd0, 1'b0, 6'b010101); step();
        drive(1'b1, 3'b000, {6{8'hE1}}, {6{8'h3C}}, 4'd5, 1'b1, 6'd0); step();
        drive(1'b1, 3'b000, {6{8'hE2}}, {6{8'h3C}}, 4'd6, 1'b1, 6'd0); step();
        drive(1'b0, 3'b000, '0, '0, 4'd0, 1'b0, 6'd0);
        chk("pre_rst_valid", 64'(wb_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(wb_valid), 64'd0);
        chk("mid_rst_mask", 64'(mask_out), 64'h3f);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        sb.delete();
        model_mask = '1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wb_ready = 1'b1;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
